// File: rtl/retro_memory_port_target_ram_pkg.sv
// Shared types and helpers for IRetroMemoryPort targets.
// Holds the refresh FSM state type, counter sizing and parameter checks.
package retro_memory_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        REFRESH = 1'b1
    } state_e;

    // Counter width for a value range 0..v-1, never narrower than 1 bit.
    function automatic int clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal parameter combinations for a RAM-backed port target.
    function automatic bit params_ok(
        input int aw,
        input int dl2,
        input int rl,
        input int ri,
        input int rc
    );
        if (dl2 < 1 || dl2 > aw) return 1'b0;
        if (rl < 1) return 1'b0;
        if (ri < 0) return 1'b0;
        if (ri != 0 && (rc < 1 || rc >= ri)) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/retro_memory_port_target_ram_if.sv
// IRetroMemoryPort: initiator/target memory link on a single clock.
// Target drives Dout/Ready/DataReady; Initiator drives the request side.
interface IRetroMemoryPort #(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1
) (
    input logic Clk
);

    logic [AddressBusWidth-1:0] Address;
    logic [8*DataBusWidth-1:0]  Din;
    logic [8*DataBusWidth-1:0]  Dout;
    logic [8*DataBusWidth-1:0]  Access;
    logic                       Write;
    logic                       Ready;
    logic                       DataReady;

    modport Target (
        input  Clk,
        input  Address,
        input  Din,
        input  Access,
        input  Write,
        output Dout,
        output Ready,
        output DataReady
    );

    modport Initiator (
        input  Clk,
        input  Dout,
        input  Ready,
        input  DataReady,
        output Address,
        output Din,
        output Access,
        output Write
    );

endinterface

// File: rtl/retro_memory_port_target_ram_read_pipe.sv
// retro_read_pipe: valid+data delay line of Depth register stages.
// Ports: i_clk, i_rst_n, i_valid/i_data in; o_valid/o_data out.
module retro_read_pipe #(
    parameter int Width = 8,
    parameter int Depth = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    output logic [Width-1:0] o_data
);

    if (Depth == 0) begin : g_thru
        assign o_valid = i_valid;
        assign o_data  = i_data;
    end else begin : g_line
        logic [Depth-1:0] r_valid;
        logic [Width-1:0] r_data [Depth];

        // Data only moves with a valid beat, so the last stage
        // keeps the most recently delivered word between beats.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= '0;
                for (int i = 0; i < Depth; i++) begin
                    r_data[i] <= '0;
                end
            end else begin
                r_valid[0] <= i_valid;
                if (i_valid) r_data[0] <= i_data;
                for (int i = 1; i < Depth; i++) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) r_data[i] <= r_data[i-1];
                end
            end
        end

        assign o_valid = r_valid[Depth-1];
        assign o_data  = r_data[Depth-1];
    end

endmodule

// File: rtl/retro_memory_port_target_ram.sv
// RAM-backed IRetroMemoryPort target with fixed read latency and optional
// refresh emulation. Ports: Clk, nReset (async, low), Port (Target).
module retro_memory_port_target_ram
    import retro_memory_pkg::*;
#(
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 1,
    parameter int DepthLog2       = 12,
    parameter int ReadLatency     = 2,
    parameter int RefreshInterval = 0,
    parameter int RefreshCycles   = 4
) (
    input logic            Clk,
    input logic            nReset,
    IRetroMemoryPort.Target Port
);

    localparam int  DW         = 8 * DataBusWidth;
    localparam int  WORDS      = 1 << DepthLog2;
    localparam int  CNT_W      = clog2_min1(RefreshInterval + 1);
    localparam bit  REFRESH_EN = (RefreshInterval != 0);
    localparam int  RUN_LAST   = REFRESH_EN ?
                                 RefreshInterval - RefreshCycles - 1 : 0;
    localparam int  REF_LAST   = RefreshCycles - 1;

    if (!params_ok(AddressBusWidth, DepthLog2, ReadLatency,
                   RefreshInterval, RefreshCycles)) begin : g_bad_params
        $error("retro_memory_port_target_ram: illegal parameters");
    end

    logic [DW-1:0]        r_mem [WORDS];

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_ready;

    logic                 w_accept;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [DepthLog2-1:0] w_idx;

    logic                 r_rd_valid;
    logic [DW-1:0]        r_rd_data;
    logic                 w_pipe_valid;
    logic [DW-1:0]        w_pipe_data;

    assign w_accept = r_ready && (Port.Access != '0);
    assign w_wr_en  = w_accept && Port.Write;
    assign w_rd_en  = w_accept && !Port.Write;
    // Upper address bits are dropped, so the array aliases.
    assign w_idx    = Port.Address[DepthLog2-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = REFRESH_EN ? r_cnt + CNT_W'(1) : '0;
        unique case (r_state)
            RUN: begin
                if (REFRESH_EN && r_cnt == CNT_W'(RUN_LAST)) begin
                    w_state_nxt = REFRESH;
                    w_cnt_nxt   = '0;
                end
            end
            REFRESH: begin
                if (r_cnt == CNT_W'(REF_LAST)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Ready follows the next state so it is low exactly while in REFRESH.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == RUN);
        end
    end

    // Storage is never reset; Access masks the bits being written.
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~Port.Access)
                          | (Port.Din & Port.Access);
        end
    end

    // Stage 1: registered RAM read.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) r_rd_data <= r_mem[w_idx];
        end
    end

    retro_read_pipe #(
        .Width (DW),
        .Depth (ReadLatency - 1)
    ) u_read_pipe (
        .i_clk   (Clk),
        .i_rst_n (nReset),
        .i_valid (r_rd_valid),
        .i_data  (r_rd_data),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data)
    );

    assign Port.Ready     = r_ready;
    assign Port.DataReady = w_pipe_valid;
    assign Port.Dout      = w_pipe_data;

endmodule

// File: tb/tb_retro_memory_port_target_ram.sv
// Bench for retro_memory_port_target_ram: a plain target and a refresh/
// aliasing target, with queued expectations checked by monitors.
module tb_retro_memory_port_target_ram;

    typedef struct packed {
        int         cyc;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    IRetroMemoryPort if_a (.Clk(clk));
    IRetroMemoryPort if_b (.Clk(clk));

    retro_memory_port_target_ram u_a (
        .Clk    (clk),
        .nReset (rst_a_n),
        .Port   (if_a)
    );

    retro_memory_port_target_ram #(
        .DepthLog2       (4),
        .RefreshInterval (16),
        .RefreshCycles   (4)
    ) u_b (
        .Clk    (clk),
        .nReset (rst_b_n),
        .Port   (if_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic wr,
                         input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] m);
        if (sel) begin
            if_b.Write = wr; if_b.Address = a;
            if_b.Din = d; if_b.Access = m;
        end else begin
            if_a.Write = wr; if_a.Address = a;
            if_a.Din = d; if_a.Access = m;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if_b.Ready : if_a.Ready;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic req(input bit sel, input logic wr,
                       input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] m, input bit push,
                       input logic [7:0] exp, output int acc);
        int   n;
        exp_t e;
        n = 0;
        drive(sel, wr, a, d, m);
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got busy want ready");
        end
        acc = cyc + 1;
        if (!wr && push) begin
            e.cyc = cyc + 2;
            e.d   = exp;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        @(negedge clk);
        drive(sel, 1'b0, 16'h0, 8'h0, 8'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if_a.DataReady) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_dr: got 1 want 0");
            end else begin
                e = q_a.pop_front();
                chk("a_dr_cycle", cyc, e.cyc);
                chk("a_dout", int'(if_a.Dout), int'(e.d));
            end
        end
        if (if_b.DataReady) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_dr: got 1 want 0");
            end else begin
                e = q_b.pop_front();
                chk("b_dr_cycle", cyc, e.cyc);
                chk("b_dout", int'(if_b.Dout), int'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int b0;
        drive(1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        drive(1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        #2;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #1;
        chk("rst_ready", int'(if_a.Ready), 0);
        chk("rst_dr", int'(if_a.DataReady), 0);
        chk("rst_dout", int'(if_a.Dout), 0);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("a_ready_up", int'(if_a.Ready), 1);

        req(0, 1, 16'h0010, 8'hA5, 8'hFF, 0, 8'h00, acc);
        req(0, 0, 16'h0010, 8'h00, 8'hFF, 1, 8'hA5, acc);
        repeat (3) @(negedge clk);

        req(0, 1, 16'h0020, 8'hFF, 8'hFF, 0, 8'h00, acc);
        req(0, 1, 16'h0020, 8'h00, 8'h0F, 0, 8'h00, acc);
        req(0, 0, 16'h0020, 8'h00, 8'hFF, 1, 8'hF0, acc);
        req(0, 0, 16'h0020, 8'h00, 8'h01, 1, 8'hF0, acc);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            req(0, 1, 16'h0100 + 16'(i), 8'(i + 1), 8'hFF,
                0, 8'h00, acc);
        end
        for (int i = 0; i < 4; i++) begin
            req(0, 0, 16'h0100 + 16'(i), 8'h00, 8'hFF,
                1, 8'(i + 1), acc);
        end
        repeat (4) @(negedge clk);
        chk("a_q_drained", q_a.size(), 0);

        req(0, 0, 16'h0102, 8'h00, 8'hFF, 0, 8'h00, acc);
        rst_a_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(if_a.Ready), 0);
        chk("mid_rst_dr", int'(if_a.DataReady), 0);
        chk("mid_rst_dout", int'(if_a.Dout), 0);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("a_ready_again", int'(if_a.Ready), 1);

        @(negedge clk);
        rst_b_n = 1'b1;
        b0 = cyc;
        fork
            begin
                bit want;
                for (int k = 1; k <= 40; k++) begin
                    @(negedge clk);
                    want = !((k >= 12 && k <= 15) ||
                             (k >= 28 && k <= 31));
                    chk($sformatf("b_ready_c%0d", k),
                        int'(if_b.Ready), int'(want));
                end
            end
            begin
                @(negedge clk);
                req(1, 1, 16'h0013, 8'h3C, 8'hFF, 0, 8'h00, acc);
                req(1, 0, 16'h0003, 8'h00, 8'hFF, 1, 8'h3C, acc);
                while (cyc - b0 < 11) @(negedge clk);
                req(1, 0, 16'h0003, 8'h00, 8'hFF, 1, 8'h3C, acc);
                chk("b_pre_refresh_acc", acc - b0, 12);
                req(1, 0, 16'h0023, 8'h00, 8'h80, 1, 8'h3C, acc);
                chk("b_held_acc", acc - b0, 17);
            end
        join
        repeat (4) @(negedge clk);
        chk("a_q_empty", q_a.size(), 0);
        chk("b_q_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
